// File: rtl/seq_alu_core.sv
// Sequential 16-opcode ALU with valid/ready handshake and iterative multiply/divide.
// Results and flags are registered and held in DONE until the consumer takes them.
module seq_alu_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 div_zero,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [3:0] OpMul = 4'd2;
  localparam logic [3:0] OpDiv = 4'd3;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d, zero_q, zero_d, dz_q, dz_d;

  logic [2*WIDTH-1:0]   alu_res;
  logic                 alu_carry;
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH:0]       mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, step;

  // Single-cycle datapath works directly on the inputs at the accept edge.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    case (op)
      4'd0: begin
        alu_res[WIDTH-1:0] = sum[WIDTH-1:0];
        alu_carry          = sum[WIDTH];
      end
      4'd1: begin
        alu_res[WIDTH-1:0] = diff[WIDTH-1:0];
        alu_carry          = diff[WIDTH];
      end
      4'd3:  alu_res = {a, {WIDTH{1'b1}}};
      4'd4:  alu_res[WIDTH-1:0] = {a[WIDTH-2:0], a[WIDTH-1]};
      4'd5:  alu_res[WIDTH-1:0] = {a[0], a[WIDTH-1:1]};
      4'd6: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (a[i]) alu_res = (2*WIDTH)'(i);
        end
      end
      4'd7:  alu_res[WIDTH-1:0] = a ^ (a >> 1);
      4'd8: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          alu_res = alu_res + (2*WIDTH)'(a[i]);
        end
      end
      4'd9:  alu_res[0] = ^a;
      4'd10: alu_res[WIDTH-1:0] = a & b;
      4'd11: alu_res[WIDTH-1:0] = a | b;
      4'd12: alu_res[WIDTH-1:0] = ~a;
      4'd13: alu_res[WIDTH-1:0] = a ^ b;
      4'd14: alu_res[0] = (a > b);
      4'd15: alu_res[0] = (a == b);
      default: alu_res = '0;
    endcase
  end

  // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
  // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, b_q};
    if (!trial[WIDTH]) begin
      div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    step = (op_q == OpMul) ? mul_next : div_next;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d  = op;
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          if (op == OpMul || (op == OpDiv && b != '0)) begin
            state_d = StExec;
            acc_d   = (op == OpMul) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
            dz_d     = (op == OpDiv);
          end
        end
      end
      StExec: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = StDone;
          result_d = step;
          carry_d  = 1'b0;
          zero_d   = (step == '0);
          dz_d     = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core: directed cases then random ops against an
// arithmetic reference model.
module tb_seq_alu_core;

  localparam int W = 8;
  localparam int unsigned M = 1 << W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       op = '0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   result;
  logic             carry, zero, div_zero, busy;

  int vectors = 0;
  int miscompares = 0;

  seq_alu_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int o, input int unsigned av, input int unsigned bv,
                                output int unsigned r, output bit c, output bit dz);
    r  = 0;
    c  = 1'b0;
    dz = 1'b0;
    case (o)
      0:  begin r = (av + bv) % M; c = (av + bv) >= M; end
      1:  begin r = (av + M - bv) % M; c = av < bv; end
      2:  r = av * bv;
      3:  begin
        if (bv == 0) begin r = av * M + (M - 1); dz = 1'b1; end
        else r = (av % bv) * M + av / bv;
      end
      4:  r = ((av * 2) % M) + av / (M / 2);
      5:  r = av / 2 + (av % 2) * (M / 2);
      6:  for (int i = 0; i < W; i++) if (((av >> i) & 1) != 0) r = i;
      7:  r = av ^ (av / 2);
      8:  r = $countones(av);
      9:  r = $countones(av) % 2;
      10: r = av & bv;
      11: r = av | bv;
      12: r = (M - 1) - av;
      13: r = av ^ bv;
      14: r = (av > bv) ? 1 : 0;
      15: r = (av == bv) ? 1 : 0;
      default: r = 0;
    endcase
  endfunction

  task automatic run_op(input int o, input int unsigned av, input int unsigned bv,
                        input int hold, input bit pulse);
    int unsigned er;
    bit          ec, edz;
    int          n;
    int          lat;
    model(o, av, bv, er, ec, edz);
    lat = (o == 2 || (o == 3 && bv != 0)) ? W + 1 : 1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    op       = 4'(o);
    a        = W'(av);
    b        = W'(bv);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check($sformatf("latency op%0d", o), n, lat);
    check($sformatf("result op%0d a=%0d b=%0d", o, av, bv), {16'd0, result}, er);
    check("carry", {31'd0, carry}, {31'd0, ec});
    check("zero", {31'd0, zero}, {31'd0, (er == 0)});
    check("div_zero", {31'd0, div_zero}, {31'd0, edz});
    check("busy_done", {30'd0, busy, in_ready}, 32'd2);
    for (int h = 0; h < hold; h++) begin
      if (pulse) in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_result", {16'd0, result}, er);
      check("hold_flags", {29'd0, carry, zero, div_zero}, {29'd0, ec, (er == 0), edz});
      check("hold_ready", {30'd0, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("taken", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    bit seen;
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {28'd0, carry, zero, div_zero, busy}, 32'd0);

    // Directed cases.
    run_op(0, 200, 100, 0, 1'b0);
    run_op(2, 15, 13, 0, 1'b0);
    run_op(2, 255, 255, 0, 1'b0);
    run_op(3, 100, 7, 0, 1'b0);
    run_op(3, 8, 0, 0, 1'b0);
    run_op(1, 3, 5, 5, 1'b1);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("no_second_result", {31'd0, seen}, 32'd0);

    // Reset in the middle of a multiply.
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    op = 4'd2; a = 8'd15; b = 8'd13; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_mul_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (W + 4) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("no_stale", {31'd0, seen}, 32'd0);

    // Single-cycle sweep.
    run_op(6, 8'h40, 0, 0, 1'b0);
    run_op(6, 0, 0, 0, 1'b0);
    run_op(7, 7, 0, 0, 1'b0);
    run_op(8, 8'hB5, 0, 0, 1'b0);
    run_op(9, 6, 0, 0, 1'b0);
    run_op(4, 8'h81, 0, 0, 1'b0);
    run_op(5, 8'h81, 0, 0, 1'b0);
    run_op(14, 7, 5, 0, 1'b0);
    run_op(15, 7, 7, 0, 1'b0);
    run_op(12, 8'h0F, 0, 0, 1'b0);

    // Randomised ops with occasional b==0 and random backpressure.
    for (int k = 0; k < 60; k++) begin
      int unsigned ro, ra, rb;
      ro = $urandom_range(0, 15);
      ra = $urandom_range(0, M - 1);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, M - 1);
      run_op(int'(ro), ra, rb, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
Parametrised successor to the 4-bit combinational ALU in the tt_um top level. It executes the same 16-opcode set on WIDTH-bit operands behind a valid/ready handshake. Multiply and divide are iterative, so their latency is multi-cycle. The block sits between the pin-decode logic and the output register bank, and reports carry, zero and divide-by-zero flags.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..16.
CW, $clog2(WIDTH+1), derived width of the iteration counter; do not override.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand/opcode presented.
in_ready  output  1  block can accept; high only in IDLE.
op  input  4  opcode, latched on accept.
a  input  WIDTH  operand A, latched on accept.
b  input  WIDTH  operand B, latched on accept.
out_valid  output  1  result/flags valid; held until taken.
out_ready  input  1  consumer takes the result.
result  output  2*WIDTH  result, zero-extended unless noted.
carry  output  1  carry (add) or borrow (sub); 0 for other ops.
zero  output  1  result == 0.
div_zero  output  1  division attempted with b == 0.
busy  output  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state goes to IDLE.
  - result, carry, zero, div_zero and out_valid go to 0; counter goes to 0.
  - Reset wins over every other event, including mid-multiply, mid-divide and in DONE with out_ready high.
  - The aborted operation produces no output.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid=1, op/a/b are latched (accept edge T).
    - op 2, or op 3 with b!=0: go to EXEC.
    - Any other case: compute in one cycle and go to DONE.
  - EXEC: one iteration per cycle for WIDTH cycles. After the WIDTH-th iteration, go to DONE.
  - DONE: out_valid=1. If out_ready=1, go to IDLE at that edge.
- Latency:
  - Single-cycle ops: out_valid rises at T+1.
  - MUL/DIV: out_valid rises at T+WIDTH+1.
  - Minimum issue interval is 2 cycles, because there is no accept in DONE.
- Backpressure: in DONE with out_ready=0, result and flags hold stable and in_ready stays 0. in_valid is ignored while in_ready=0.
- Opcodes (a, b unsigned):
  - 0 ADD: result = a+b, truncated to WIDTH bits; carry = bit WIDTH of the sum.
  - 1 SUB: result = (a-b) mod 2^WIDTH; carry = (a<b).
  - 2 MUL: result = a*b, full 2*WIDTH bits, via shift-add over WIDTH iterations.
  - 3 DIV: restoring division over WIDTH iterations; result = {remainder, quotient}.
    - If b==0: takes one cycle, result = {a, all-ones}, div_zero=1.
  - 4 ROTL: a rotated left by 1.
  - 5 ROTR: a rotated right by 1.
  - 6 PENC: index of the highest set bit of a; 0 if a==0 (zero flag then set).
  - 7 GRAY: a ^ (a>>1).
  - 8 POPCNT: number of ones in a.
  - 9 PARITY: XOR reduction of a (1 bit).
  - 10 AND, 11 OR, 13 XOR: bitwise a,b.
  - 12 NOT: ~a, WIDTH bits.
  - 14 GT: (a>b), 1 bit.
  - 15 EQ: (a==b), 1 bit.
- Width and flag rules:
  - Upper bits of result are 0 except for MUL and DIV.
  - zero is evaluated on the full 2*WIDTH-bit result. div_zero is 0 for every op except DIV with b==0.
  - All flags update together with result and are held with it.

Test Plan:
1. WIDTH=8, ADD a=200 b=100 → at T+1: result=0x002C, carry=1, zero=0; with out_ready=1, in_ready returns at T+2.
2. MUL a=15 b=13 → out_valid first high at T+9; result=0x00C3. MUL a=255 b=255 → result=0xFE01.
3. DIV a=100 b=7 → at T+9: result=0x020E (rem 2, quot 14). DIV a=8 b=0 → at T+1: result=0x08FF, div_zero=1.
4. Backpressure: hold out_ready=0 for 5 cycles after SUB a=3 b=5. Required: result=0x00FE and carry=1 stay stable; in_ready=0; in_valid pulses are ignored (no second result is produced).
5. Reset mid-op: MUL starts, rst=1 at T+4. Required: next cycle state IDLE, out_valid=0, result=0, in_ready=1; no stale output appears afterwards.
6. Single-cycle sweep: PENC a=0x40→6; PENC a=0→0 with zero=1; GRAY 7→4; POPCNT 0xB5→5; PARITY 6→0; ROTL 0x81→0x03; GT 7,5→1; EQ 7,7→1.
